// File: rtl/stage3_seq_num_bank.sv
// ---------------------------------------------------------------------------
// stage3_seq_num_bank
//
// Bank of CHANNELS independent sequence-number counters behind a
// valid/ready request port and a single registered response port.
// Each accepted request either loads a channel's counter or takes its
// current value and post-increments it. The response appears one cycle
// after acceptance and is held while downstream stalls.
//
// Optional feature (macro STAGE3_SEQ_GAP_CHECK_EN):
//   Receive-side gap checking. On an increment request req_value carries
//   the received sequence number. A mismatch against the counter flags
//   rsp_gap, bumps a saturating 16-bit gap_count and resyncs the counter
//   to req_value + 1.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   rst_n      in   synchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when high with req_valid
//   req_chan   in   [CH_BITS]  target channel
//   req_load   in   1 = load counter, 0 = take-and-increment
//   req_value  in   [SEQ_BITS] load value / received seq (gap check)
//   rsp_valid  out  response present
//   rsp_ready  in   downstream accepts response
//   rsp_chan   out  [CH_BITS]  channel of response
//   rsp_seq    out  [SEQ_BITS] sequence number issued
//   rsp_wrap   out  counter wrapped on this transaction
//   rsp_err    out  request targeted channel >= CHANNELS
//   rsp_gap    out  (gap check only) received seq mismatched counter
//   gap_count  out  (gap check only) [16] saturating gap counter
// ---------------------------------------------------------------------------
module stage3_seq_num_bank #(
   parameter int                  CHANNELS   = 4,
   parameter int                  SEQ_BITS   = 32,
   parameter logic [SEQ_BITS-1:0] INIT_VALUE = SEQ_BITS'(1),
   localparam int                 CH_BITS    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [CH_BITS-1:0]  req_chan,
   input  logic                req_load,
   input  logic [SEQ_BITS-1:0] req_value,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [CH_BITS-1:0]  rsp_chan,
   output logic [SEQ_BITS-1:0] rsp_seq,
   output logic                rsp_wrap,
`ifdef STAGE3_SEQ_GAP_CHECK_EN
   output logic                rsp_err,
   output logic                rsp_gap,
   output logic [15:0]         gap_count
`else
   output logic                rsp_err
`endif
);

   localparam logic [SEQ_BITS-1:0] SEQ_ONE = SEQ_BITS'(1);

`ifdef STAGE3_SEQ_GAP_CHECK_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
`endif

   logic [SEQ_BITS-1:0] cnt_mem [CHANNELS];

   logic                accept_p0;
   logic                chan_ok_p0;
   logic                upd_p0;
   logic                wrap_p0;
   logic [SEQ_BITS-1:0] cur_p0;
   logic [SEQ_BITS-1:0] nxt_p0;
   logic [SEQ_BITS-1:0] seq_p0;

   logic                vld_p1;
   logic [CH_BITS-1:0]  chan_p1;
   logic [SEQ_BITS-1:0] seq_p1;
   logic                wrap_p1;
   logic                err_p1;

`ifdef STAGE3_SEQ_GAP_CHECK_EN
   logic                gap_p0;
   logic                gap_p1;
   logic [15:0]         gap_cnt_p1;
`endif

   // ---- stage p0: request decode and counter next-value ----
   // The output register refills in the same cycle it drains, so a
   // continuously-ready consumer sees one response per cycle.
   assign req_ready = !vld_p1 || rsp_ready;
   assign accept_p0 = req_valid && req_ready;

   always_comb begin
      chan_ok_p0 = int'(req_chan) < CHANNELS;
      cur_p0     = '0;
      nxt_p0     = '0;
      seq_p0     = '0;
      wrap_p0    = 1'b0;
      upd_p0     = 1'b0;
`ifdef STAGE3_SEQ_GAP_CHECK_EN
      gap_p0     = 1'b0;
`endif
      // Out-of-range channels never touch the array; they only return
      // an error response with a zero sequence number.
      if (chan_ok_p0) begin
         cur_p0 = cnt_mem[req_chan];
         upd_p0 = 1'b1;
         if (req_load) begin
            nxt_p0 = req_value;
            seq_p0 = req_value;
         end
`ifdef STAGE3_SEQ_GAP_CHECK_EN
         else if (req_value != cur_p0) begin
            // Resync to the received number so the next in-order packet
            // matches again.
            gap_p0 = 1'b1;
            seq_p0 = req_value;
            nxt_p0 = req_value + SEQ_ONE;
         end
`endif
         else begin
            seq_p0  = cur_p0;
            nxt_p0  = cur_p0 + SEQ_ONE;
            wrap_p0 = &cur_p0;
         end
      end
   end

   // Counter array: written in the accept cycle, so a back-to-back request
   // to the same channel reads the updated value on the next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_mem[i] <= INIT_VALUE;
         end
      end else if (accept_p0 && upd_p0) begin
         cnt_mem[req_chan] <= nxt_p0;
      end
   end

   // ---- stage p1: registered response ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         chan_p1 <= '0;
         seq_p1  <= '0;
         wrap_p1 <= 1'b0;
         err_p1  <= 1'b0;
      end else if (accept_p0) begin
         vld_p1  <= 1'b1;
         chan_p1 <= req_chan;
         seq_p1  <= seq_p0;
         wrap_p1 <= wrap_p0;
         err_p1  <= !chan_ok_p0;
      end else if (rsp_ready) begin
         vld_p1  <= 1'b0;
      end
   end

`ifdef STAGE3_SEQ_GAP_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gap_p1     <= 1'b0;
         gap_cnt_p1 <= 16'd0;
      end else if (accept_p0) begin
         gap_p1 <= gap_p0;
         if (gap_p0) begin
            gap_cnt_p1 <= sat_inc16(gap_cnt_p1);
         end
      end
   end

   assign rsp_gap   = gap_p1;
   assign gap_count = gap_cnt_p1;
`endif

   assign rsp_valid = vld_p1;
   assign rsp_chan  = chan_p1;
   assign rsp_seq   = seq_p1;
   assign rsp_wrap  = wrap_p1;
   assign rsp_err   = err_p1;

endmodule

// File: tb/tb_stage3_seq_num_bank.sv
// ---------------------------------------------------------------------------
// tb_stage3_seq_num_bank
//
// Directed bench for stage3_seq_num_bank built with CHANNELS=3 so that
// channel 3 is an invalid target. A behavioural model (counter array plus
// expected response state) is checked against the DUT on every negedge;
// directed literal expectations are checked 1 time unit after posedges.
// Gap-check vectors are included when STAGE3_SEQ_GAP_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_stage3_seq_num_bank;

   localparam int NCH = 3;

`ifdef STAGE3_SEQ_GAP_CHECK_EN
   localparam bit GAP = 1'b1;
`else
   localparam bit GAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_chan;
   logic        req_load;
   logic [31:0] req_value;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_chan;
   logic [31:0] rsp_seq;
   logic        rsp_wrap;
   logic        rsp_err;
`ifdef STAGE3_SEQ_GAP_CHECK_EN
   logic        rsp_gap;
   logic [15:0] gap_count;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stage3_seq_num_bank #(
      .CHANNELS  (NCH),
      .SEQ_BITS  (32),
      .INIT_VALUE(32'd1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_chan (req_chan),
      .req_load (req_load),
      .req_value(req_value),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_chan (rsp_chan),
      .rsp_seq  (rsp_seq),
      .rsp_wrap (rsp_wrap),
`ifdef STAGE3_SEQ_GAP_CHECK_EN
      .rsp_err  (rsp_err),
      .rsp_gap  (rsp_gap),
      .gap_count(gap_count)
`else
      .rsp_err  (rsp_err)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   logic [31:0] m_cnt [NCH];
   bit          m_vld;
   logic [1:0]  m_chan;
   logic [31:0] m_seq;
   bit          m_wrap, m_err, m_gap;
   int          m_gapcnt;

   // Inputs change only 1 unit after a posedge, so what is seen at a
   // negedge is what the following posedge will sample.
   initial begin
      bit started;
      bit rdy;
      started = 1'b0;
      forever begin
         @(negedge clk);
         if (started) begin
            chk("m.rsp_valid", rsp_valid, m_vld);
            chk("m.req_ready", req_ready, !m_vld || rsp_ready);
            if (m_vld) begin
               chk("m.rsp_chan", rsp_chan, m_chan);
               chk("m.rsp_seq",  rsp_seq,  m_seq);
               chk("m.rsp_wrap", rsp_wrap, m_wrap);
               chk("m.rsp_err",  rsp_err,  m_err);
`ifdef STAGE3_SEQ_GAP_CHECK_EN
               chk("m.rsp_gap",  rsp_gap,  m_gap);
`endif
            end
`ifdef STAGE3_SEQ_GAP_CHECK_EN
            chk("m.gap_count", gap_count, m_gapcnt);
`endif
         end
         // Advance the model by the effect of the upcoming posedge.
         if (!rst_n) begin
            for (int i = 0; i < NCH; i++) m_cnt[i] = 32'd1;
            m_vld = 0; m_chan = 0; m_seq = 0; m_wrap = 0; m_err = 0; m_gap = 0;
            m_gapcnt = 0;
         end else begin
            rdy = !m_vld || rsp_ready;
            if (req_valid && rdy) begin
               m_vld  = 1;
               m_chan = req_chan;
               m_wrap = 0; m_err = 0; m_gap = 0;
               if (int'(req_chan) >= NCH) begin
                  m_err = 1;
                  m_seq = 0;
               end else if (req_load) begin
                  m_cnt[req_chan] = req_value;
                  m_seq = req_value;
               end else if (GAP && req_value != m_cnt[req_chan]) begin
                  m_gap = 1;
                  m_seq = req_value;
                  m_cnt[req_chan] = req_value + 32'd1;
                  if (m_gapcnt < 65535) m_gapcnt++;
               end else begin
                  m_seq  = m_cnt[req_chan];
                  m_wrap = (m_cnt[req_chan] == 32'hFFFF_FFFF);
                  m_cnt[req_chan] = m_cnt[req_chan] + 32'd1;
               end
            end else if (rsp_ready) begin
               m_vld = 0;
            end
         end
         started = 1'b1;
      end
   end

   // ---------------- directed stimulus with literal expectations ----------
   // Drives one request (called 1 unit after a posedge), lets it be accepted
   // on the next posedge and checks the literal response right after it.
   task automatic req(input logic [1:0] ch, input bit ld, input logic [31:0] v,
                      input logic [31:0] es, input bit ew, input bit ee, input string nm);
      req_valid = 1'b1;
      req_chan  = ch;
      req_load  = ld;
      req_value = v;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({nm, ".vld"},  rsp_valid, 1'b1);
      chk({nm, ".chan"}, rsp_chan, ch);
      chk({nm, ".seq"},  rsp_seq,  es);
      chk({nm, ".wrap"}, rsp_wrap, ew);
      chk({nm, ".err"},  rsp_err,  ee);
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_chan  = 2'd0;
      req_load  = 1'b0;
      req_value = 32'd0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.rsp_valid", rsp_valid, 1'b0);
      chk("rst.rsp_seq",   rsp_seq,   32'd0);
      chk("rst.rsp_chan",  rsp_chan,  2'd0);
      chk("rst.rsp_wrap",  rsp_wrap,  1'b0);
      chk("rst.rsp_err",   rsp_err,   1'b0);
`ifdef STAGE3_SEQ_GAP_CHECK_EN
      chk("rst.rsp_gap",   rsp_gap,   1'b0);
      chk("rst.gap_count", gap_count, 16'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel.req_ready", req_ready, 1'b1);

      // Three back-to-back increments on channel 2.
      req(2'd2, 0, 32'd1, 32'd1, 0, 0, "inc2a");
      req(2'd2, 0, 32'd2, 32'd2, 0, 0, "inc2b");
      req(2'd2, 0, 32'd3, 32'd3, 0, 0, "inc2c");
      // Load all-ones then wrap.
      req(2'd1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "ld1");
      req(2'd1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, "wrap1");
      req(2'd1, 0, 32'd0,         32'd0,         0, 0, "post1");
      // Untouched channel 0 still at its reset value; channel 1 continues.
      req(2'd0, 0, 32'd1, 32'd1, 0, 0, "inc0");
      req(2'd1, 0, 32'd1, 32'd1, 0, 0, "inc1");
      // Invalid channel: error, zero seq, nothing modified.
      req(2'd3, 0, 32'd0,  32'd0, 0, 1, "err_inc");
      req(2'd3, 1, 32'h55, 32'd0, 0, 1, "err_ld");
      req(2'd0, 0, 32'd2, 32'd2, 0, 0, "after_err0");
      req(2'd1, 0, 32'd2, 32'd2, 0, 0, "after_err1");
      req(2'd2, 0, 32'd4, 32'd4, 0, 0, "after_err2");
      @(posedge clk); #1;
      chk("idle.rsp_valid", rsp_valid, 1'b0);

      // Stall: downstream not ready for 4 cycles with a request pending.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_chan = 2'd0; req_load = 1'b0; req_value = 32'd3;
      @(posedge clk); #1;
      chk("stall.first", rsp_seq, 32'd3);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         chk("stall.vld",   rsp_valid, 1'b1);
         chk("stall.hold",  rsp_seq,   32'd3);
         chk("stall.ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1; req_value = 32'd4;
      @(posedge clk); #1;
      chk("stall.next", rsp_seq, 32'd4);
      req_value = 32'd5;
      @(posedge clk); #1;
      chk("stall.next2", rsp_seq, 32'd5);
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("stall.drain", rsp_valid, 1'b0);

      // Reset while a response is stalled.
      rsp_ready = 1'b0;
      req(2'd2, 0, 32'd5, 32'd5, 0, 0, "pre_rst");
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst.rsp_valid", rsp_valid, 1'b0);
      chk("midrst.rsp_seq",   rsp_seq,   32'd0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      chk("midrst.req_ready", req_ready, 1'b1);
      req(2'd2, 0, 32'd1, 32'd1, 0, 0, "reinit2");
      req(2'd0, 0, 32'd1, 32'd1, 0, 0, "reinit0");
      req(2'd1, 0, 32'd1, 32'd1, 0, 0, "reinit1");

`ifdef STAGE3_SEQ_GAP_CHECK_EN
      req(2'd0, 1, 32'd5, 32'd5, 0, 0, "gap_ld");
      req(2'd0, 0, 32'd8, 32'd8, 0, 0, "gap_hit");
      chk("gap_hit.rsp_gap", rsp_gap,   1'b1);
      chk("gap_hit.count",   gap_count, 16'd1);
      req(2'd0, 0, 32'd9, 32'd9, 0, 0, "gap_ok");
      chk("gap_ok.rsp_gap",  rsp_gap,   1'b0);
      chk("gap_ok.count",    gap_count, 16'd1);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
